// File: rtl/shift_arb_ctrl.sv
// Two-requester arbiter feeding a WIDTH-bit MSB-first serializer.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module shift_arb_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             busy,
   output logic             done,
   output logic             owner
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done_q, done_d;
   logic             owner_q, owner_d;
   logic             win;

   always_comb begin
`ifdef SHIFT_ARB_RR_EN
      win = (req0 & req1) ? ~owner_q : req1;
`else
      win = (req0 & req1) ? 1'b0 : req1;
`endif
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = SHIFT;
               shreg_d = win ? data1 : data0;
               cnt_d   = '0;
               owner_d = win;
               gnt0_d  = ~win;
               gnt1_d  = win;
            end
         end
         SHIFT: begin
            // The final shift empties shreg, so sdo reads 0 again once IDLE.
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done_q  <= 1'b0;
         owner_q <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done_q  <= done_d;
         owner_q <= owner_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign done      = done_q;
   assign owner     = owner_q;
   assign busy      = (state_q == SHIFT);
   assign sdo_valid = (state_q == SHIFT);
   assign sdo       = shreg_q[WIDTH-1];

endmodule
